// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder: FSM states,
// load/store type encodings and default sizing.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Matches the load-store unit instruction_type field.
    typedef enum logic [1:0] {
        REQ_LW = 2'b00,
        REQ_LB = 2'b01,
        REQ_SW = 2'b10,
        REQ_SB = 2'b11
    } req_type_t;

    localparam int DEFAULT_DEPTH_WORDS = 256;
    localparam int DEFAULT_LATENCY     = 2;
    localparam int CNT_W               = 4;

    function automatic logic type_is_store(input logic [1:0] t);
        return (t == REQ_SW) || (t == REQ_SB);
    endfunction

    // Word-sized accesses must be 4-byte aligned.
    function automatic logic type_is_word(input logic [1:0] t);
        return (t == REQ_LW) || (t == REQ_SW);
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane logic: load extraction with LB sign extension, and
// store merge of SW/SB data into the previously stored word.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  access_type,
    input  logic [1:0]  byte_off,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] merged
);

    logic [7:0]  old_bytes [4];
    logic [31:0] sb_word;
    logic [7:0]  sel_byte;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign old_bytes[gi]      = old_word[gi*8 +: 8];
            assign sb_word[gi*8 +: 8] = (byte_off == 2'(gi)) ? wdata[7:0] : old_word[gi*8 +: 8];
        end
    endgenerate

    assign sel_byte = old_bytes[byte_off];

    always_comb begin
        rdata  = '0;
        merged = old_word;
        case (access_type)
            REQ_LW:  rdata  = old_word;
            REQ_LB:  rdata  = {{24{sel_byte[7]}}, sel_byte};
            REQ_SW:  merged = wdata;
            REQ_SB:  merged = sb_word;
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed access latency and a
// valid/ready response channel carrying ROB and physical-register tags.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int LATENCY     = DEFAULT_LATENCY
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [5:0]  req_rob_idx,
    input  logic [5:0]  req_phys_rd,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [5:0]  rsp_rob_idx,
    output logic [5:0]  rsp_phys_rd,
    output logic        rsp_is_store,
    output logic        rsp_err
);

    localparam int               AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(LATENCY - 1);
    localparam logic [29:0]      DEPTH_LIM = 30'(DEPTH_WORDS);

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_reg;

    logic             accept;
    logic             execute;
    logic             req_err;
    logic [AW-1:0]    req_idx;

    logic [1:0]       type_reg;
    logic [AW-1:0]    idx_reg;
    logic [1:0]       off_reg;
    logic [31:0]      wdata_reg;
    logic [5:0]       rob_reg;
    logic [5:0]       phys_reg;
    logic             err_reg;
    logic [31:0]      old_word_reg;

    logic [31:0]      rsp_rdata_reg;
    logic [5:0]       rsp_rob_idx_reg;
    logic [5:0]       rsp_phys_rd_reg;
    logic             rsp_is_store_reg;
    logic             rsp_err_reg;

    logic [31:0]      lane_rdata;
    logic [31:0]      lane_merged;

    logic [31:0]      mem [DEPTH_WORDS];

    // Error is decided at acceptance so the memory port never sees a bad index.
    assign req_err = (req_addr[31:2] >= DEPTH_LIM)
                   || (type_is_word(req_type) && (req_addr[1:0] != 2'b00));
    assign req_idx = req_addr[AW+1:2];

    assign accept  = req_valid && req_ready;
    assign execute = (state_reg == ST_ACCESS) && (cnt_reg == '0);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (accept)    state_next = ST_ACCESS;
            ST_ACCESS: if (execute)   state_next = ST_RESP;
            ST_RESP:   if (rsp_ready) state_next = ST_IDLE;
            default:                  state_next = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready = (state_reg == ST_IDLE) && !reset;
        rsp_valid = (state_reg == ST_RESP);
    end

    // Only one request is in flight, so the word read at acceptance is still
    // current when the read-modify-write executes LATENCY edges later.
    always_ff @(posedge clk) begin
        if (execute && !reset && type_is_store(type_reg) && !err_reg) begin
            mem[idx_reg] <= lane_merged;
        end
        if (accept) begin
            old_word_reg <= mem[req_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg          <= '0;
            type_reg         <= '0;
            idx_reg          <= '0;
            off_reg          <= '0;
            wdata_reg        <= '0;
            rob_reg          <= '0;
            phys_reg         <= '0;
            err_reg          <= 1'b0;
            rsp_rdata_reg    <= '0;
            rsp_rob_idx_reg  <= '0;
            rsp_phys_rd_reg  <= '0;
            rsp_is_store_reg <= 1'b0;
            rsp_err_reg      <= 1'b0;
        end else begin
            if (accept) begin
                cnt_reg   <= CNT_LOAD;
                type_reg  <= req_type;
                idx_reg   <= req_idx;
                off_reg   <= req_addr[1:0];
                wdata_reg <= req_wdata;
                rob_reg   <= req_rob_idx;
                phys_reg  <= req_phys_rd;
                err_reg   <= req_err;
            end else if ((state_reg == ST_ACCESS) && (cnt_reg != '0)) begin
                cnt_reg <= cnt_reg - 1'b1;
            end

            if (execute) begin
                rsp_rdata_reg    <= err_reg ? 32'd0 : lane_rdata;
                rsp_rob_idx_reg  <= rob_reg;
                rsp_phys_rd_reg  <= phys_reg;
                rsp_is_store_reg <= type_is_store(type_reg);
                rsp_err_reg      <= err_reg;
            end
        end
    end

    dmem_lane_align u_lane_align (
        .access_type (type_reg),
        .byte_off    (off_reg),
        .old_word    (old_word_reg),
        .wdata       (wdata_reg),
        .rdata       (lane_rdata),
        .merged      (lane_merged)
    );

    assign rsp_rdata    = rsp_rdata_reg;
    assign rsp_rob_idx  = rsp_rob_idx_reg;
    assign rsp_phys_rd  = rsp_phys_rd_reg;
    assign rsp_is_store = rsp_is_store_reg;
    assign rsp_err      = rsp_err_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Drives three responders (LATENCY 1, 2, 4) in lockstep and checks every
// response against a byte-addressed reference memory.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int NI = 3;

    function automatic int lat_of(input int i);
        case (i)
            0:       return 1;
            1:       return 2;
            default: return 4;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [1:0]  req_type;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [5:0]  req_rob_idx;
    logic [5:0]  req_phys_rd;
    logic        rsp_ready;

    logic        req_ready_w    [NI];
    logic        rsp_valid_w    [NI];
    logic [31:0] rsp_rdata_w    [NI];
    logic [5:0]  rsp_rob_idx_w  [NI];
    logic [5:0]  rsp_phys_rd_w  [NI];
    logic        rsp_is_store_w [NI];
    logic        rsp_err_w      [NI];

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mb [1024];

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            dmem_responder #(
                .DEPTH_WORDS (256),
                .LATENCY     (lat_of(gi))
            ) u_dut (
                .clk          (clk),
                .reset        (reset),
                .req_valid    (req_valid),
                .req_ready    (req_ready_w[gi]),
                .req_type     (req_type),
                .req_addr     (req_addr),
                .req_wdata    (req_wdata),
                .req_rob_idx  (req_rob_idx),
                .req_phys_rd  (req_phys_rd),
                .rsp_valid    (rsp_valid_w[gi]),
                .rsp_ready    (rsp_ready),
                .rsp_rdata    (rsp_rdata_w[gi]),
                .rsp_rob_idx  (rsp_rob_idx_w[gi]),
                .rsp_phys_rd  (rsp_phys_rd_w[gi]),
                .rsp_is_store (rsp_is_store_w[gi]),
                .rsp_err      (rsp_err_w[gi])
            );
        end
    endgenerate

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic string tname(input logic [1:0] t);
        case (t)
            2'b00:   return "LW";
            2'b01:   return "LB";
            2'b10:   return "SW";
            default: return "SB";
        endcase
    endfunction

    // Reference: byte-addressed little-endian memory, updated when a request is issued.
    task automatic model(input logic [1:0] t, input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic err);
        int ia;
        bit is_word;
        is_word = (t == 2'b00) || (t == 2'b10);
        err = ((a >> 2) >= 32'd256) || (is_word && (a % 4 != 0));
        rd  = 32'd0;
        if (!err) begin
            ia = int'(a);
            case (t)
                2'b00: rd = {mb[ia+3], mb[ia+2], mb[ia+1], mb[ia]};
                2'b01: rd = {{24{mb[ia][7]}}, mb[ia]};
                2'b10: for (int k = 0; k < 4; k++) mb[ia+k] = wd[8*k +: 8];
                default: mb[ia] = wd[7:0];
            endcase
        end
    endtask

    task automatic txn(input logic [1:0] t, input logic [31:0] a, input logic [31:0] wd,
                       input logic [5:0] rob, input logic [5:0] phys, input int stall);
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_store;
        int          lat_seen [NI];
        int          cyc;
        bit          all_seen;
        model(t, a, wd, exp_rdata, exp_err);
        exp_store = (t == 2'b10) || (t == 2'b11);

        @(negedge clk);
        for (int i = 0; i < NI; i++) check($sformatf("req_ready_idle_lat%0d", lat_of(i)), 32'(req_ready_w[i]), 32'd1);
        req_valid   = 1'b1;
        req_type    = t;
        req_addr    = a;
        req_wdata   = wd;
        req_rob_idx = rob;
        req_phys_rd = phys;
        @(posedge clk);
        #1;
        req_valid = 1'b0;

        cyc = 0;
        for (int i = 0; i < NI; i++) lat_seen[i] = rsp_valid_w[i] ? 0 : -1;
        all_seen = 1'b0;
        while (!all_seen && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
            all_seen = 1'b1;
            for (int i = 0; i < NI; i++) begin
                if (lat_seen[i] < 0 && rsp_valid_w[i]) lat_seen[i] = cyc;
                if (lat_seen[i] < 0) all_seen = 1'b0;
            end
        end
        for (int i = 0; i < NI; i++) check($sformatf("latency_lat%0d", lat_of(i)), 32'(lat_seen[i]), 32'(lat_of(i)));

        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NI; i++) begin
                check($sformatf("stall_valid_lat%0d", lat_of(i)), 32'(rsp_valid_w[i]), 32'd1);
                check($sformatf("stall_rdata_lat%0d", lat_of(i)), rsp_rdata_w[i], exp_rdata);
                check($sformatf("stall_ready_lat%0d", lat_of(i)), 32'(req_ready_w[i]), 32'd0);
            end
        end

        for (int i = 0; i < NI; i++) begin
            check($sformatf("rdata_lat%0d", lat_of(i)),    rsp_rdata_w[i], exp_rdata);
            check($sformatf("err_lat%0d", lat_of(i)),      32'(rsp_err_w[i]), 32'(exp_err));
            check($sformatf("is_store_lat%0d", lat_of(i)), 32'(rsp_is_store_w[i]), 32'(exp_store));
            check($sformatf("rob_lat%0d", lat_of(i)),      32'(rsp_rob_idx_w[i]), 32'(rob));
            check($sformatf("phys_lat%0d", lat_of(i)),     32'(rsp_phys_rd_w[i]), 32'(phys));
        end
        $display("txn %s addr=%h wdata=%h rob=%0d stall=%0d exp_rdata=%h exp_err=%0d",
                 tname(t), a, wd, rob, stall, exp_rdata, exp_err);

        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("post_hs_valid_lat%0d", lat_of(i)), 32'(rsp_valid_w[i]), 32'd0);
            check($sformatf("post_hs_ready_lat%0d", lat_of(i)), 32'(req_ready_w[i]), 32'd1);
        end
    endtask

    // Reset asserted on the edge after acceptance: every instance is still in ACCESS.
    task automatic reset_in_access(input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        req_valid   = 1'b1;
        req_type    = REQ_SW;
        req_addr    = a;
        req_wdata   = wd;
        req_rob_idx = 6'd9;
        req_phys_rd = 6'd9;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("rst_acc_valid_lat%0d", lat_of(i)), 32'(rsp_valid_w[i]), 32'd0);
            check($sformatf("rst_acc_ready_lat%0d", lat_of(i)), 32'(req_ready_w[i]), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NI; i++) begin
                check($sformatf("rst_acc_norsp_lat%0d", lat_of(i)), 32'(rsp_valid_w[i]), 32'd0);
                check($sformatf("rst_acc_idle_lat%0d", lat_of(i)), 32'(req_ready_w[i]), 32'd1);
            end
        end
        $display("txn SW addr=%h wdata=%h abandoned by reset", a, wd);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  t;
        logic [31:0] a;
        int          st;

        reset       = 1'b1;
        req_valid   = 1'b0;
        req_type    = 2'b00;
        req_addr    = '0;
        req_wdata   = '0;
        req_rob_idx = '0;
        req_phys_rd = '0;
        rsp_ready   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("rst_ready_lat%0d", lat_of(i)),    32'(req_ready_w[i]), 32'd0);
            check($sformatf("rst_valid_lat%0d", lat_of(i)),    32'(rsp_valid_w[i]), 32'd0);
            check($sformatf("rst_rdata_lat%0d", lat_of(i)),    rsp_rdata_w[i], 32'd0);
            check($sformatf("rst_err_lat%0d", lat_of(i)),      32'(rsp_err_w[i]), 32'd0);
            check($sformatf("rst_is_store_lat%0d", lat_of(i)), 32'(rsp_is_store_w[i]), 32'd0);
            check($sformatf("rst_rob_lat%0d", lat_of(i)),      32'(rsp_rob_idx_w[i]), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) check($sformatf("ready_after_rst_lat%0d", lat_of(i)), 32'(req_ready_w[i]), 32'd1);

        // Basic store then load
        txn(REQ_SW, 32'h10, 32'hDEADBEEF, 6'd3, 6'd11, 0);
        txn(REQ_LW, 32'h10, 32'h0,        6'd4, 6'd12, 0);
        // Byte store merge and sign-extended byte load
        txn(REQ_SB, 32'h11, 32'h00000080, 6'd5, 6'd13, 0);
        txn(REQ_LW, 32'h10, 32'h0,        6'd6, 6'd14, 0);
        txn(REQ_LB, 32'h11, 32'h0,        6'd7, 6'd15, 0);
        // Misaligned and out-of-range accesses
        txn(REQ_SW, 32'h0,   32'hA5A50001, 6'd8,  6'd16, 0);
        txn(REQ_LW, 32'h12,  32'h0,        6'd9,  6'd17, 0);
        txn(REQ_SW, 32'h400, 32'hFFFFFFFF, 6'd10, 6'd18, 0);
        txn(REQ_LW, 32'h0,   32'h0,        6'd11, 6'd19, 0);
        // Back-pressure on the response channel
        txn(REQ_LW, 32'h10,  32'h0,        6'd12, 6'd20, 5);
        // Reset during ACCESS abandons the store
        txn(REQ_SW, 32'h20, 32'h0BADF00D, 6'd13, 6'd21, 0);
        reset_in_access(32'h20, 32'h00001234);
        txn(REQ_LW, 32'h20, 32'h0,        6'd14, 6'd22, 0);

        for (int w = 0; w < 16; w++) txn(REQ_SW, 32'(w * 4), $urandom, 6'($urandom), 6'($urandom), 0);
        for (int n = 0; n < 60; n++) begin
            t  = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 9) < 8) ? 32'($urandom_range(0, 63)) : ($urandom | 32'h400);
            st = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            txn(t, a, $urandom, 6'($urandom), 6'($urandom), st);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
